motion_block_sequencer: RTL and testbench

Top-level scheduler for one motion block. It accepts a move command and runs the shared per-axis timing unit once per active axis, reducing the results to per-phase maxima. It then drives calc_all_new_parameters to rescale every axis to the common timing, and hands the rescaled block to the step executor. Planning of block N+1 overlaps execution of block N through a single ready-buffer.

---
 rtl/motion_pkg.sv | 29 ++
 rtl/timing_max_reduce.sv | 23 ++
 rtl/motion_block_sequencer.sv | 165 ++++++++++++++++
 tb/tb_motion_block_sequencer.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/motion_pkg.sv
// Shared types and constants for the motion block sequencer.
// Axis ordering is x, y, z, e0, e1; parameter word 0 of each axis is its step count.
package motion_pkg;

  localparam int unsigned N_AXES   = 5;
  localparam int unsigned N_PAR    = 5;
  localparam int unsigned N_PHASES = 4;
  localparam int unsigned N_WORDS  = N_AXES * N_PAR;
  localparam int unsigned AXIS_W   = $clog2(N_AXES);
  localparam int unsigned WORD_W   = $clog2(N_WORDS);

  typedef logic [31:0] axis_params_t [0:N_PAR-1];
  typedef logic [63:0] timing_t [0:N_PHASES-1];

  typedef enum logic [2:0] {
    IDLE, LATCH, TREQ, TWAIT, CAP_RUN, CAP_GAP, PARK
  } state_t;

  // Lowest active axis at or above start; MSB of the result is the found flag.
  function automatic logic [AXIS_W:0] next_active(input logic [N_AXES-1:0] mask, input int start);
    logic [AXIS_W:0] r;
    r = '0;
    for (int a = N_AXES - 1; a >= 0; a--) begin
      if (mask[a] && a >= start) r = {1'b1, AXIS_W'(a)};
    end
    return r;
  endfunction

endpackage

// File: rtl/timing_max_reduce.sv
// Four-lane unsigned 64-bit running-maximum register with synchronous clear.
module timing_max_reduce
  import motion_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    clear,
  input  logic    accumulate,
  input  timing_t timing_in,
  output timing_t max_out
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      for (int k = 0; k < N_PHASES; k++) max_out[k] <= '0;
    end else if (accumulate) begin
      for (int k = 0; k < N_PHASES; k++) begin
        if (timing_in[k] > max_out[k]) max_out[k] <= timing_in[k];
      end
    end
  end

endmodule

// File: rtl/motion_block_sequencer.sv
// Plans one motion block at a time (per-axis timing, max reduction, rescale)
// and hands finished blocks to the executor through a single ready-buffer.
module motion_block_sequencer
  import motion_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 2,
  parameter logic [31:0] TIMEOUT    = 32'd1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_const_speed,
  input  logic [31:0] cmd_params [0:N_WORDS-1],
  output logic        tc_start,
  output logic [31:0] tc_params [0:N_PAR-1],
  input  logic [63:0] tc_timing [0:N_PHASES-1],
  input  logic        tc_finish,
  output logic        cap_start,
  output logic        cap_const_speed,
  output logic [31:0] cap_params [0:N_WORDS-1],
  output logic [63:0] cap_max_timing [0:N_PHASES-1],
  input  logic [31:0] cap_new_params [0:N_WORDS-1],
  input  logic        cap_finish,
  output logic        exe_start,
  output logic [31:0] exe_params [0:N_WORDS-1],
  input  logic        exe_busy,
  output logic        busy,
  output logic        error
);

  state_t              state_q, state_d;
  logic [AXIS_W-1:0]   axis_q, axis_d;
  logic [31:0]         cnt_q, cnt_d;
  logic                buf_full_q, buf_full_d;
  logic                err_d;
  logic [31:0]         result_q [0:N_WORDS-1];
  logic [31:0]         buf_q    [0:N_WORDS-1];
  logic [N_AXES-1:0]   active_c;
  logic [AXIS_W:0]     first_c, next_c;
  logic                handshake_c, accum_c, capture_c, park_c, issue_c;

  timing_max_reduce u_max (
    .clk        (clk),
    .reset      (reset),
    .clear      (handshake_c),
    .accumulate (accum_c),
    .timing_in  (tc_timing),
    .max_out    (cap_max_timing)
  );

  // Next-state, watchdog and buffer control.
  always_comb begin
    state_d     = state_q;
    axis_d      = axis_q;
    buf_full_d  = buf_full_q;
    err_d       = error;
    handshake_c = 1'b0;
    accum_c     = 1'b0;
    capture_c   = 1'b0;
    park_c      = 1'b0;
    issue_c     = buf_full_q && !exe_busy && !exe_start;
    for (int a = 0; a < N_AXES; a++) active_c[a] = (cap_params[a * N_PAR] != '0);
    first_c = next_active(active_c, 0);
    next_c  = next_active(active_c, int'(axis_q) + 1);

    case (state_q)
      IDLE: if (cmd_valid && cmd_ready) begin
        handshake_c = 1'b1;
        axis_d      = '0;
        state_d     = LATCH;
      end
      LATCH: begin
        if (first_c[AXIS_W]) begin
          axis_d  = first_c[AXIS_W-1:0];
          state_d = TREQ;
        end else begin
          state_d = IDLE;
        end
      end
      TREQ: state_d = TWAIT;
      TWAIT: if (tc_finish) begin
        accum_c = 1'b1;
        if (next_c[AXIS_W]) begin
          axis_d  = next_c[AXIS_W-1:0];
          state_d = TREQ;
        end else begin
          state_d = CAP_RUN;
        end
      end
      CAP_RUN: if (cap_finish) begin
        capture_c = 1'b1;
        state_d   = CAP_GAP;
      end
      CAP_GAP: if (cnt_q == 32'(GAP_CYCLES - 1)) state_d = PARK;
      PARK: if (!buf_full_q || issue_c) begin
        park_c  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Watchdog abandons the block and locks out new commands until reset.
    if ((state_q inside {TWAIT, CAP_RUN, PARK}) && cnt_q >= TIMEOUT - 32'd1) begin
      state_d   = IDLE;
      err_d     = 1'b1;
      capture_c = 1'b0;
      park_c    = 1'b0;
    end

    if (issue_c) buf_full_d = 1'b0;
    if (park_c)  buf_full_d = 1'b1;
    if (err_d && !error) buf_full_d = 1'b0;

    if (state_d != state_q)                                 cnt_d = '0;
    else if (state_q inside {TWAIT, CAP_RUN, CAP_GAP, PARK}) cnt_d = cnt_q + 32'd1;
    else                                                     cnt_d = cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      axis_q          <= '0;
      cnt_q           <= '0;
      buf_full_q      <= 1'b0;
      cmd_ready       <= 1'b1;
      tc_start        <= 1'b0;
      cap_start       <= 1'b0;
      cap_const_speed <= 1'b0;
      exe_start       <= 1'b0;
      busy            <= 1'b0;
      error           <= 1'b0;
      for (int p = 0; p < N_PAR; p++) tc_params[p] <= '0;
      for (int i = 0; i < N_WORDS; i++) begin
        cap_params[i] <= '0;
        result_q[i]   <= '0;
        buf_q[i]      <= '0;
        exe_params[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      axis_q     <= axis_d;
      cnt_q      <= cnt_d;
      buf_full_q <= buf_full_d;
      error      <= err_d;
      cmd_ready  <= (state_d == IDLE) && !err_d && !buf_full_d;
      tc_start   <= (state_d == TREQ);
      cap_start  <= (state_d == CAP_RUN);
      exe_start  <= issue_c;
      busy       <= (state_d != IDLE) || buf_full_d;
      if (state_d == TREQ) begin
        for (int p = 0; p < N_PAR; p++)
          tc_params[p] <= cap_params[WORD_W'(int'(axis_d) * int'(N_PAR) + p)];
      end
      if (handshake_c) begin
        cap_params      <= cmd_params;
        cap_const_speed <= cmd_const_speed;
      end
      if (capture_c) result_q   <= cap_new_params;
      if (issue_c)   exe_params <= buf_q;
      if (park_c)    buf_q      <= result_q;
    end
  end

endmodule

// File: tb/tb_motion_block_sequencer.sv
// Bench for motion_block_sequencer with timing-unit and rescaler stubs.
module tb_motion_block_sequencer;

  typedef logic [31:0] flat_t [0:24];
  typedef logic [31:0] ap_t   [0:4];
  typedef logic [63:0] tm_t   [0:3];

  logic  clk = 1'b0;
  logic  reset, cmd_valid, cmd_ready, cmd_const_speed;
  flat_t cmd_params;
  logic  tc_start, tc_finish;
  ap_t   tc_params;
  tm_t   tc_timing;
  logic  cap_start, cap_const_speed, cap_finish;
  flat_t cap_params, cap_new_params, exe_params;
  tm_t   cap_max_timing;
  logic  exe_start, exe_busy, busy, error;

  int   n_vec = 0;
  int   n_err = 0;
  bit   cap_en = 1'b1;
  int   cap_cnt = 0;
  logic cap_prev = 1'b0;

  ap_t   tc_log[$];
  tm_t   cap_log[$];
  logic  cs_log[$];
  flat_t exe_log[$];

  always #5 clk = ~clk;

  motion_block_sequencer #(.GAP_CYCLES(2), .TIMEOUT(32'd50)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_const_speed(cmd_const_speed), .cmd_params(cmd_params),
    .tc_start(tc_start), .tc_params(tc_params), .tc_timing(tc_timing), .tc_finish(tc_finish),
    .cap_start(cap_start), .cap_const_speed(cap_const_speed), .cap_params(cap_params),
    .cap_max_timing(cap_max_timing), .cap_new_params(cap_new_params), .cap_finish(cap_finish),
    .exe_start(exe_start), .exe_params(exe_params), .exe_busy(exe_busy),
    .busy(busy), .error(error)
  );

  // ---------------- reference model ----------------
  function automatic tm_t stub_timing(input ap_t p);
    tm_t t;
    for (int k = 0; k < 4; k++) t[k] = {24'd0, p[k+1][31:24], p[k+1]};
    return t;
  endfunction

  function automatic flat_t rescale(input flat_t c);
    flat_t r;
    for (int i = 0; i < 25; i++) r[i] = c[i] * 32'd3 + 32'd7;
    return r;
  endfunction

  function automatic ap_t axis_of(input flat_t c, input int a);
    ap_t p;
    for (int j = 0; j < 5; j++) p[j] = c[a*5 + j];
    return p;
  endfunction

  function automatic tm_t exp_max(input flat_t c);
    tm_t m, t;
    for (int k = 0; k < 4; k++) m[k] = 64'd0;
    for (int a = 0; a < 5; a++) begin
      if (c[a*5] != 32'd0) begin
        t = stub_timing(axis_of(c, a));
        for (int k = 0; k < 4; k++) if (t[k] > m[k]) m[k] = t[k];
      end
    end
    return m;
  endfunction

  // ---------------- stubs and monitor ----------------
  initial begin : timing_stub
    ap_t p;
    tc_finish = 1'b0;
    for (int k = 0; k < 4; k++) tc_timing[k] = 64'd0;
    forever begin
      if (tc_start === 1'b1) begin
        p = tc_params;
        repeat (3) @(posedge clk);
        #1;
        tc_timing = stub_timing(p);
        tc_finish = 1'b1;
        @(posedge clk); #1;
        tc_finish = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
    end
  end

  initial begin : cap_stub
    cap_finish = 1'b0;
    for (int i = 0; i < 25; i++) cap_new_params[i] = 32'd0;
    forever begin
      @(posedge clk); #1;
      if (cap_start === 1'b1 && cap_en) begin
        if (cap_cnt == 3) begin
          cap_new_params = rescale(cap_params);
          cap_finish     = 1'b1;
        end else cap_cnt++;
      end else begin
        cap_cnt    = 0;
        cap_finish = 1'b0;
      end
    end
  end

  initial begin : monitor
    forever begin
      @(posedge clk); #1;
      if (tc_start === 1'b1) tc_log.push_back(tc_params);
      if (cap_start === 1'b1 && cap_prev !== 1'b1) begin
        cap_log.push_back(cap_max_timing);
        cs_log.push_back(cap_const_speed);
      end
      cap_prev = cap_start;
      if (exe_start === 1'b1) exe_log.push_back(exe_params);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clear_logs();
    tc_log.delete(); cap_log.delete(); cs_log.delete(); exe_log.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic send_cmd(input flat_t c, input logic cs, output bit ok);
    cmd_params = c; cmd_const_speed = cs; cmd_valid = 1'b1; ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (cmd_ready === 1'b1) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL send_cmd: cmd_ready actual 0 required 1 within 300 cycles");
    end
  endtask

  task automatic wait_quiet();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (busy === 1'b0) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL wait_quiet: busy actual 1 required 0 within 400 cycles");
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  function automatic flat_t zero_cmd();
    flat_t c;
    for (int i = 0; i < 25; i++) c[i] = 32'd0;
    return c;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset cmd_ready: actual %b required 1", cmd_ready); end
    n_vec++; if (busy !== 1'b0)      begin n_err++; $display("FAIL reset busy: actual %b required 0", busy); end
    n_vec++; if (error !== 1'b0)     begin n_err++; $display("FAIL reset error: actual %b required 0", error); end
    n_vec++; if ({tc_start, cap_start, exe_start} !== 3'b000) begin
      n_err++; $display("FAIL reset starts: actual %b required 000", {tc_start, cap_start, exe_start});
    end
    n_vec++; if (cap_max_timing[3] !== 64'd0) begin n_err++; $display("FAIL reset max: actual %0d required 0", cap_max_timing[3]); end
    n_vec++; if (exe_params[24] !== 32'd0) begin n_err++; $display("FAIL reset exe_params: actual %0d required 0", exe_params[24]); end
  endtask

  task automatic test_single_move();
    flat_t c, e; tm_t m; bit ok; int bad;
    c = zero_cmd();
    c[0] = 32'd100; c[1] = 32'd10; c[2] = 32'd20; c[3] = 32'd30; c[4] = 32'd40;
    m[0] = 64'd10; m[1] = 64'd20; m[2] = 64'd30; m[3] = 64'd40;
    clear_logs();
    send_cmd(c, 1'b1, ok);
    wait_quiet();
    n_vec++; if (tc_log.size() != 1) begin n_err++; $display("FAIL single tc_count: actual %0d required 1", tc_log.size()); end
    else begin
      n_vec++; if (tc_log[0][0] !== 32'd100) begin n_err++; $display("FAIL single tc_steps: actual %0d required 100", tc_log[0][0]); end
    end
    n_vec++; if (cap_log.size() != 1) begin n_err++; $display("FAIL single cap_count: actual %0d required 1", cap_log.size()); end
    else begin
      bad = 0; for (int k = 0; k < 4; k++) if (cap_log[0][k] !== m[k]) bad++;
      n_vec++; if (bad != 0) begin n_err++; $display("FAIL single max: actual %0d,%0d,%0d,%0d required 10,20,30,40",
        cap_log[0][0], cap_log[0][1], cap_log[0][2], cap_log[0][3]); end
      n_vec++; if (cs_log[0] !== 1'b1) begin n_err++; $display("FAIL single const_speed: actual %b required 1", cs_log[0]); end
    end
    e = rescale(c);
    n_vec++; if (exe_log.size() != 1) begin n_err++; $display("FAIL single exe_count: actual %0d required 1", exe_log.size()); end
    else begin
      bad = 0; for (int i = 0; i < 25; i++) if (exe_log[0][i] !== e[i]) bad++;
      n_vec++; if (bad != 0) begin n_err++; $display("FAIL single exe_params: %0d words differ, word0 actual %0d required %0d", bad, exe_log[0][0], e[0]); end
    end
  endtask

  task automatic test_two_axes();
    flat_t c; bit ok; int bad;
    c = zero_cmd();
    c[0] = 32'd7; c[1] = 32'd5; c[2] = 32'd50; c[3] = 32'd5; c[4] = 32'd5;
    c[5] = 32'd9; c[6] = 32'd9; c[7] = 32'd7;  c[8] = 32'd9; c[9] = 32'd1;
    clear_logs();
    send_cmd(c, 1'b0, ok);
    wait_quiet();
    n_vec++; if (tc_log.size() != 2) begin n_err++; $display("FAIL two tc_count: actual %0d required 2", tc_log.size()); end
    else begin
      n_vec++; if (tc_log[0][0] !== 32'd7 || tc_log[1][0] !== 32'd9) begin
        n_err++; $display("FAIL two tc_order: actual %0d,%0d required 7,9", tc_log[0][0], tc_log[1][0]);
      end
    end
    n_vec++; if (cap_log.size() != 1) begin n_err++; $display("FAIL two cap_count: actual %0d required 1", cap_log.size()); end
    else begin
      bad = 0;
      if (cap_log[0][0] !== 64'd9) bad++;
      if (cap_log[0][1] !== 64'd50) bad++;
      if (cap_log[0][2] !== 64'd9) bad++;
      if (cap_log[0][3] !== 64'd5) bad++;
      n_vec++; if (bad != 0) begin n_err++; $display("FAIL two max: actual %0d,%0d,%0d,%0d required 9,50,9,5",
        cap_log[0][0], cap_log[0][1], cap_log[0][2], cap_log[0][3]); end
    end
    n_vec++; if (exe_log.size() != 1) begin n_err++; $display("FAIL two exe_count: actual %0d required 1", exe_log.size()); end
  endtask

  task automatic test_noop();
    flat_t c; bit ok;
    c = zero_cmd();
    for (int i = 0; i < 25; i++) if (i % 5 != 0) c[i] = 32'd1 + 32'(i);
    clear_logs();
    send_cmd(c, 1'b0, ok);
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL noop busy: actual %b required 0", busy); end
    repeat (20) @(posedge clk);
    #1;
    n_vec++; if (tc_log.size() + cap_log.size() + exe_log.size() != 0) begin
      n_err++; $display("FAIL noop activity: actual tc=%0d cap=%0d exe=%0d required 0,0,0", tc_log.size(), cap_log.size(), exe_log.size());
    end
    n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL noop cmd_ready: actual %b required 1", cmd_ready); end
  endtask

  task automatic test_back_to_back();
    flat_t c1, c2, e; bit ok; int bad;
    c1 = zero_cmd(); c2 = zero_cmd();
    for (int i = 0; i < 5; i++) begin
      c1[i] = 32'd11 + 32'(i); c1[10+i] = 32'd40 + 32'(i); c2[5+i] = 32'd70 + 32'(i);
    end
    clear_logs();
    exe_busy = 1'b1;
    send_cmd(c1, 1'b0, ok);
    repeat (40) @(posedge clk);
    #1;
    n_vec++; if (exe_log.size() != 0) begin n_err++; $display("FAIL b2b held: actual %0d issues required 0", exe_log.size()); end
    n_vec++; if ({busy, cmd_ready} !== 2'b10) begin n_err++; $display("FAIL b2b parked: actual busy,ready=%b required 10", {busy, cmd_ready}); end
    exe_busy = 1'b0;
    @(posedge clk); #1;
    exe_busy = 1'b1;
    send_cmd(c2, 1'b1, ok);
    repeat (40) @(posedge clk);
    #1;
    e = rescale(c1);
    n_vec++; if (exe_log.size() != 1) begin n_err++; $display("FAIL b2b first_count: actual %0d required 1", exe_log.size()); end
    else begin
      bad = 0; for (int i = 0; i < 25; i++) if (exe_log[0][i] !== e[i]) bad++;
      n_vec++; if (bad != 0) begin n_err++; $display("FAIL b2b first_params: %0d words differ", bad); end
    end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b second_parked: actual busy %b required 1", busy); end
    exe_busy = 1'b0;
    wait_quiet();
    e = rescale(c2);
    n_vec++; if (exe_log.size() != 2) begin n_err++; $display("FAIL b2b second_count: actual %0d required 2", exe_log.size()); end
    else begin
      bad = 0; for (int i = 0; i < 25; i++) if (exe_log[1][i] !== e[i]) bad++;
      n_vec++; if (bad != 0) begin n_err++; $display("FAIL b2b second_params: %0d words differ", bad); end
    end
  endtask

  task automatic test_random();
    flat_t c, e; tm_t m; logic [4:0] mask; logic cs; bit ok; int bad, nact, idx;
    for (int n = 0; n < 10; n++) begin
      mask = 5'($urandom_range(0, 31));
      cs   = 1'($urandom_range(0, 1));
      nact = 0;
      for (int a = 0; a < 5; a++) begin
        for (int j = 0; j < 5; j++) c[a*5 + j] = $urandom;
        if (!mask[a]) c[a*5] = 32'd0;
        else begin
          nact++;
          if (c[a*5] == 32'd0) c[a*5] = 32'd1;
        end
      end
      clear_logs();
      send_cmd(c, cs, ok);
      wait_quiet();
      n_vec++; if (tc_log.size() != nact) begin n_err++; $display("FAIL rand%0d tc_count: actual %0d required %0d", n, tc_log.size(), nact); end
      else begin
        bad = 0; idx = 0;
        for (int a = 0; a < 5; a++) if (mask[a]) begin
          for (int j = 0; j < 5; j++) if (tc_log[idx][j] !== c[a*5 + j]) bad++;
          idx++;
        end
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL rand%0d tc_params: %0d words differ", n, bad); end
      end
      if (nact == 0) begin
        n_vec++; if (cap_log.size() + exe_log.size() != 0) begin
          n_err++; $display("FAIL rand%0d noop: actual cap=%0d exe=%0d required 0,0", n, cap_log.size(), exe_log.size());
        end
      end else begin
        m = exp_max(c); e = rescale(c);
        n_vec++; if (cap_log.size() != 1) begin n_err++; $display("FAIL rand%0d cap_count: actual %0d required 1", n, cap_log.size()); end
        else begin
          bad = 0; for (int k = 0; k < 4; k++) if (cap_log[0][k] !== m[k]) bad++;
          n_vec++; if (bad != 0) begin n_err++; $display("FAIL rand%0d max: lane0 actual %h required %h", n, cap_log[0][0], m[0]); end
          n_vec++; if (cs_log[0] !== cs) begin n_err++; $display("FAIL rand%0d const_speed: actual %b required %b", n, cs_log[0], cs); end
        end
        n_vec++; if (exe_log.size() != 1) begin n_err++; $display("FAIL rand%0d exe_count: actual %0d required 1", n, exe_log.size()); end
        else begin
          bad = 0; for (int i = 0; i < 25; i++) if (exe_log[0][i] !== e[i]) bad++;
          n_vec++; if (bad != 0) begin n_err++; $display("FAIL rand%0d exe_params: %0d words differ", n, bad); end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    flat_t c, e; bit ok, seen; int bad;
    c = zero_cmd();
    for (int i = 0; i < 5; i++) c[10+i] = 32'd200 + 32'(i);
    clear_logs();
    send_cmd(c, 1'b1, ok);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (tc_start === 1'b1) begin seen = 1'b1; break; end
      @(posedge clk); #1;
    end
    n_vec++; if (!seen) begin n_err++; $display("FAIL rstmid tc_start: actual 0 required 1 within 20 cycles"); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    n_vec++; if ({cmd_ready, busy, error, tc_start, cap_start, exe_start} !== 6'b100000) begin
      n_err++; $display("FAIL rstmid flags: actual %b required 100000", {cmd_ready, busy, error, tc_start, cap_start, exe_start});
    end
    n_vec++; if (cap_params[10] !== 32'd0 || tc_params[0] !== 32'd0 || cap_const_speed !== 1'b0) begin
      n_err++; $display("FAIL rstmid data: actual cap_params=%0d tc_params=%0d cs=%b required 0,0,0", cap_params[10], tc_params[0], cap_const_speed);
    end
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    c[0] = 32'd3; c[2] = 32'h0500_0001;
    clear_logs();
    send_cmd(c, 1'b0, ok);
    wait_quiet();
    e = rescale(c);
    n_vec++; if (exe_log.size() != 1) begin n_err++; $display("FAIL rstmid exe_count: actual %0d required 1", exe_log.size()); end
    else begin
      bad = 0; for (int i = 0; i < 25; i++) if (exe_log[0][i] !== e[i]) bad++;
      n_vec++; if (bad != 0) begin n_err++; $display("FAIL rstmid exe_params: %0d words differ", bad); end
    end
  endtask

  task automatic test_timeout();
    flat_t c; bit ok, seen; int n_hi, n_rdy;
    c = zero_cmd();
    c[0] = 32'd5; c[1] = 32'd1;
    cap_en = 1'b0;
    clear_logs();
    send_cmd(c, 1'b0, ok);
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (cap_start === 1'b1) begin seen = 1'b1; break; end
      @(posedge clk); #1;
    end
    n_vec++; if (!seen) begin n_err++; $display("FAIL timeout cap_start: actual 0 required 1 within 60 cycles"); end
    n_hi = seen ? 1 : 0;
    for (int i = 0; i < 200 && seen; i++) begin
      @(posedge clk); #1;
      if (cap_start === 1'b1) n_hi++;
      else break;
    end
    n_vec++; if (n_hi != 50) begin n_err++; $display("FAIL timeout cap_run_len: actual %0d required 50", n_hi); end
    n_vec++; if ({error, cap_start, cmd_ready} !== 3'b100) begin
      n_err++; $display("FAIL timeout flags: actual error,cap_start,ready=%b required 100", {error, cap_start, cmd_ready});
    end
    cmd_valid = 1'b1; n_rdy = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (cmd_ready !== 1'b0) n_rdy++;
    end
    cmd_valid = 1'b0;
    n_vec++; if (n_rdy != 0 || exe_log.size() != 0) begin
      n_err++; $display("FAIL timeout lockout: actual ready_cycles=%0d issues=%0d required 0,0", n_rdy, exe_log.size());
    end
    cap_en = 1'b1;
    do_reset();
    n_vec++; if ({error, cmd_ready} !== 2'b01) begin n_err++; $display("FAIL timeout recover: actual error,ready=%b required 01", {error, cmd_ready}); end
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_const_speed = 1'b0; exe_busy = 1'b0;
    cmd_params = zero_cmd();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    test_reset();
    test_single_move();
    test_two_axes();
    test_noop();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
